// File: rtl/ifetch_buf.sv
// ifetch_buf: PC generator, imem request/response port and fetch queue feeding decode
//   clk, rst                    clock, synchronous active-high reset
//   branch_i, branch_pc_i       redirect from EX
//   flush_i, flush_pc_i         redirect from trap/CSR, wins over branch
//   imem_req_valid_o/ready_i    fetch request handshake, imem_req_addr_o = word-aligned pc
//   imem_rsp_valid_i/data_i     in-order, never back-pressured instruction response
//   id_valid_o/ready_i          queue head handshake to decode, id_pc_o/id_inst_o = head entry
module ifetch_buf #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FETCH_DEPTH = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_inst_o
);
  localparam int AW = $clog2(FETCH_DEPTH);
  localparam int CW = $clog2(FETCH_DEPTH + 1);
  localparam int RW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
  localparam logic [CW-1:0] DEPTH = CW'(FETCH_DEPTH);
  localparam logic [CW-1:0] MAXO = CW'(MAX_OUT);
  localparam logic [RW-1:0] RLAST = RW'(MAX_OUT - 1);
  logic [XLEN-1:0] pc_q, pc_d, target;
  logic [CW-1:0] fq_cnt_q, fq_cnt_d, out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [CW:0] in_use;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [RW-1:0] rp_wr_q, rp_wr_d, rp_rd_q, rp_rd_d;
  logic [XLEN-1:0] fq_pc_q [FETCH_DEPTH];
  logic [XLEN-1:0] fq_inst_q [FETCH_DEPTH];
  logic [XLEN-1:0] rp_pc_q [MAX_OUT];
  logic redir, accept, push, pop;
  always_comb begin
    redir = flush_i | branch_i;
    target = (flush_i ? flush_pc_i : branch_pc_i) & ~XLEN'(3);
    // queued entries plus live requests in flight; doomed requests hold no credit
    in_use = {1'b0, fq_cnt_q} + {1'b0, out_cnt_q} - {1'b0, drop_cnt_q};
    imem_req_valid_o = !rst && !redir && out_cnt_q < MAXO && in_use < {1'b0, DEPTH};
    imem_req_addr_o = pc_q;
    accept = imem_req_valid_o && imem_req_ready_i;
    id_valid_o = fq_cnt_q != '0 && !redir;
    id_pc_o = fq_cnt_q != '0 ? fq_pc_q[head_q] : '0;
    id_inst_o = fq_cnt_q != '0 ? fq_inst_q[head_q] : '0;
    pop = id_valid_o && id_ready_i;
    push = imem_rsp_valid_i && !redir && drop_cnt_q == '0;
    pc_d = redir ? target : accept ? pc_q + XLEN'(4) : pc_q;
    out_cnt_d = out_cnt_q + CW'(accept) - CW'(imem_rsp_valid_i);
    // every request still in flight after a redirect belongs to the wrong path
    drop_cnt_d = redir ? out_cnt_q - CW'(imem_rsp_valid_i)
                       : drop_cnt_q - CW'(imem_rsp_valid_i && drop_cnt_q != '0);
    fq_cnt_d = redir ? '0 : fq_cnt_q + CW'(push) - CW'(pop);
    head_d = redir ? '0 : head_q + AW'(pop);
    tail_d = redir ? '0 : tail_q + AW'(push);
    rp_wr_d = !accept ? rp_wr_q : rp_wr_q == RLAST ? '0 : rp_wr_q + RW'(1);
    rp_rd_d = !imem_rsp_valid_i ? rp_rd_q : rp_rd_q == RLAST ? '0 : rp_rd_q + RW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      fq_cnt_q <= '0;
      out_cnt_q <= '0;
      drop_cnt_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      rp_wr_q <= '0;
      rp_rd_q <= '0;
    end else begin
      assert (!(push && !pop && fq_cnt_q == DEPTH));
      pc_q <= pc_d;
      fq_cnt_q <= fq_cnt_d;
      out_cnt_q <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rp_wr_q <= rp_wr_d;
      rp_rd_q <= rp_rd_d;
    end
  end
  // request PCs ride alongside the in-order responses, dropped ones included
  always_ff @(posedge clk) begin
    if (accept) rp_pc_q[rp_wr_q] <= pc_q;
    if (push) begin
      fq_pc_q[tail_q] <= rp_pc_q[rp_rd_q];
      fq_inst_q[tail_q] <= imem_rsp_data_i;
    end
  end
endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: directed bench for ifetch_buf with a queue-level reference model
module tb_ifetch_buf;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;
  localparam logic [31:0] RPC = 32'h0;
  typedef struct {logic [31:0] addr; bit wrong;} out_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  typedef struct {int due; logic [31:0] addr;} mem_t;
  logic clk = 0, rst, branch, flush, ready, rsp_valid, id_ready;
  logic [31:0] branch_pc, flush_pc, rsp_data, req_addr, id_pc, id_inst;
  logic req_valid, id_valid;
  int total = 0, bad = 0, cyc = 0, lat = 1, n;
  logic [31:0] m_pc;
  out_t m_out[$];
  ent_t m_fq[$];
  mem_t mem_q[$];
  logic [31:0] acc_log[$], pop_log[$];
  int acc_cyc[$], pop_cyc[$];
  ifetch_buf #(.XLEN(32), .RESET_PC(RPC), .FETCH_DEPTH(DEPTH), .MAX_OUT(MAXO)) dut (
    .clk(clk), .rst(rst), .branch_i(branch), .branch_pc_i(branch_pc), .flush_i(flush),
    .flush_pc_i(flush_pc), .imem_req_valid_o(req_valid), .imem_req_ready_i(ready),
    .imem_req_addr_o(req_addr), .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .id_valid_o(id_valid), .id_ready_i(id_ready), .id_pc_o(id_pc), .id_inst_o(id_inst)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_logs();
    acc_log.delete();
    pop_log.delete();
    acc_cyc.delete();
    pop_cyc.delete();
  endtask
  task automatic do_reset(input int l);
    rst = 1;
    lat = l;
    branch = 0;
    flush = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_inst", id_inst, 0);
    @(posedge clk);
    #1;
    rst = 0;
    clear_logs();
  endtask
  // memory: answers accepted requests in order, lat cycles after the accept
  initial begin
    rsp_valid = 0;
    rsp_data = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        rsp_valid = 1;
        rsp_data = memf(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        rsp_valid = 0;
        rsp_data = 0;
      end
    end
  end
  // reference model: outstanding requests tagged wrong-path, fetch queue of {pc, inst}
  always @(negedge clk) begin : model
    logic redir, e_rv, e_iv;
    int live;
    out_t o;
    logic [31:0] tgt;
    redir = flush | branch;
    live = 0;
    foreach (m_out[i]) if (!m_out[i].wrong) live++;
    e_rv = !rst && !redir && m_out.size() < MAXO && (m_fq.size() + live) < DEPTH;
    e_iv = m_fq.size() != 0 && !redir;
    if (!rst) begin
      chk("req_valid", req_valid, e_rv);
      if (e_rv) chk("req_addr", req_addr, m_pc);
      chk("id_valid", id_valid, e_iv);
      if (e_iv) begin
        chk("id_pc", id_pc, m_fq[0].pc);
        chk("id_inst", id_inst, m_fq[0].inst);
      end
    end
    if (req_valid && ready) begin
      acc_log.push_back(req_addr);
      acc_cyc.push_back(cyc);
      mem_q.push_back('{cyc + lat, req_addr});
    end
    if (id_valid && id_ready) begin
      pop_log.push_back(id_pc);
      pop_cyc.push_back(cyc);
    end
    if (rst) begin
      m_pc = RPC;
      m_fq.delete();
      m_out.delete();
      mem_q.delete();
    end else begin
      if (e_iv && id_ready) void'(m_fq.pop_front());
      if (rsp_valid) begin
        chk("rsp_expected", m_out.size() != 0, 1);
        if (m_out.size() != 0) begin
          o = m_out.pop_front();
          if (!redir && !o.wrong) m_fq.push_back('{o.addr, memf(o.addr)});
        end
      end
      if (e_rv && ready) begin
        m_out.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 4;
      end
      if (redir) begin
        foreach (m_out[i]) m_out[i].wrong = 1;
        m_fq.delete();
        tgt = flush ? flush_pc : branch_pc;
        m_pc = {tgt[31:2], 2'b00};
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int wild;
    rst = 1; branch = 0; flush = 0; branch_pc = 0; flush_pc = 0; ready = 1; id_ready = 1;
    do_reset(1);
    step(12);
    chk("t1_npop", pop_log.size() >= 3, 1);
    chk("t1_acc0", acc_log[0], 32'h0);
    chk("t1_acc1", acc_log[1], 32'h4);
    for (int i = 0; i < 3; i++) chk($sformatf("t1_pop%0d", i), pop_log[i], 32'(4 * i));
    chk("t1_rate", pop_cyc[2] - pop_cyc[0], 2);
    chk("t1_latency", pop_cyc[0] - acc_cyc[0], 2);
    do_reset(1);
    id_ready = 0;
    step(12);
    @(negedge clk);
    chk("t2_stall_rv", req_valid, 0);
    chk("t2_nacc", acc_log.size(), DEPTH);
    chk("t2_nopop", pop_log.size(), 0);
    step(1);
    id_ready = 1;
    step(10);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_drain%0d", i), pop_log[i], 32'(4 * i));
    do_reset(3);
    n = 0;
    while (mem_q.size() != 2 && n < 20) begin step(1); n++; end
    chk("t3_setup", mem_q.size(), 2);
    clear_logs();
    branch = 1; branch_pc = 32'h100;
    step(1);
    branch = 0;
    step(16);
    chk("t3_acc0", acc_log[0], 32'h100);
    chk("t3_acc1", acc_log[1], 32'h104);
    chk("t3_pop0", pop_log[0], 32'h100);
    clear_logs();
    flush = 1; flush_pc = 32'h200; branch = 1; branch_pc = 32'h100;
    step(1);
    flush = 0; branch = 0;
    step(16);
    chk("t4_acc0", acc_log[0], 32'h200);
    chk("t4_pop0", pop_log[0], 32'h200);
    wild = 0;
    foreach (pop_log[i]) if (pop_log[i] >= 32'h100 && pop_log[i] < 32'h200) wild++;
    chk("t4_no_branch_path", wild, 0);
    clear_logs();
    branch = 1; branch_pc = 32'h103;
    step(1);
    branch = 0;
    step(10);
    chk("t5_align_acc", acc_log[0], 32'h100);
    chk("t5_align_pop", pop_log[0], 32'h100);
    clear_logs();
    branch = 1; branch_pc = 32'hFFFF_FFFC;
    step(1);
    branch = 0;
    step(10);
    chk("t5_wrap_acc0", acc_log[0], 32'hFFFF_FFFC);
    chk("t5_wrap_acc1", acc_log[1], 32'h0);
    chk("t5_wrap_pop1", pop_log[1], 32'h0);
    do_reset(2);
    for (int i = 0; i < 40; i++) begin
      ready = (i % 3) != 0;
      id_ready = (i % 4) != 1;
      branch = i == 20;
      branch_pc = 32'h40;
      step(1);
    end
    ready = 1; id_ready = 1; branch = 0;
    step(10);
    chk("mix_progress", pop_log.size() > 5, 1);
    do_reset(3);
    id_ready = 0;
    n = 0;
    while (!(mem_q.size() == 2 && m_fq.size() == 2) && n < 20) begin step(1); n++; end
    chk("t6_setup", mem_q.size() == 2 && m_fq.size() == 2, 1);
    do_reset(3);
    id_ready = 1;
    step(12);
    chk("t6_acc0", acc_log[0], RPC);
    chk("t6_pop0", pop_log[0], 32'h0);
    chk("t6_pop1", pop_log[1], 32'h4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
